acc16_seq: RTL and testbench
============================

# acc16_seq

Sequential accumulator controller that sits directly upstream of the 16-bit ripple add/sub stage, `alu4`, and also consumes its output. It accepts commands over a valid/ready handshake and drives one `alu4` instance with `in1` = accumulator and `in2` = latched operand. `alu4.opcode` is 1 only for SUB. The block registers the sum or difference back into the accumulator and reports status flags. It adds LOAD, and a multi-cycle multiply-accumulate performed by repeated addition through the same stage.

## Interface
- `WIDTH`, 16, datapath width; fixed to match `alu4`; other values unsupported
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  2  00 LOAD, 01 ADD, 10 SUB, 11 MAC
- `cmd_operand`  in  16  operand, two's complement
- `cmd_count`  in  4  MAC repeat count; ignored for other ops
- `acc`  out  16  accumulator register
- `done`  out  1  one-cycle pulse: command complete, `acc` and flags final
- `zero`  out  1  `acc == 0`, combinational from `acc`
- `neg`  out  1  `acc[15]`
- `ovf`  out  1  registered signed-overflow flag, sticky within one command

## Operation
- States: IDLE, RUN, DONE.
- `cmd_ready` = (state == IDLE) && !`reset`.
- **Accept**
  - A command is accepted at the edge where `cmd_valid && cmd_ready`.
  - On that edge the block latches op, operand and count.
  - The run counter is loaded with k: k = 1 for LOAD/ADD/SUB; k = max(1, `cmd_count`) for MAC.
  - `ovf` is cleared, and state goes IDLE→RUN.
- **RUN, one pass per cycle**, with the counter decrementing each edge:
  - LOAD: `acc` <= operand, and the `alu4` result is unused.
  - ADD or MAC: `acc` <= `alu4`(`acc`, operand, 0).
  - SUB: `acc` <= `alu4`(`acc`, operand, 1), giving `acc` − operand.
  - MAC with `cmd_count` = 0: one RUN cycle, `acc` unchanged, `ovf` stays 0.
- **Overflow detection**
  - Let b' = operand XOR {16{sub}}.
  - Overflow occurs when `acc[15]` == b'[15] and result[15] != `acc[15]`.
  - On overflow, `ovf` <= 1 and stays set until the next accept.
  - LOAD never sets `ovf`.
- Arithmetic is modulo 2^16: results wrap with no saturation, and no carry-out is reported.
- After the last RUN edge, state goes RUN→DONE.
- DONE lasts exactly one cycle with `done` = 1, then goes to IDLE.
- **Ignored inputs**
  - `cmd_valid` is ignored while not ready.
  - The requester holds the command until accepted.
  - Changes to `cmd_*` after acceptance have no effect.
- **Reset**
  - Reset is honoured in any state, including mid-RUN.
  - On reset the in-flight command is abandoned with no `done` pulse.
  - Reset values: state IDLE, `acc` 0x0000, `ovf` 0, `done` 0, counter 0.
  - Derived outputs after reset: `zero` 1, `neg` 0.
  - `cmd_ready` is 0 while `reset` is high and 1 in the first cycle after release.

## Timing
- Accept edge E0; RUN cycles end at edges E1..Ek; `acc` is updated at each Ei.
- `done` is high for the cycle between Ek and Ek+1, and `acc`/`ovf` are final in that cycle.
- `cmd_ready` rises at Ek+1, so throughput is one command per k+2 cycles.
- Single-op latency is 2 edges from accept to the end of the `done` cycle.
- `alu4` is combinational inside the RUN cycle: a 16-stage ripple path from the `acc` and operand registers to the `acc` D input. No pipelining.
- `zero` and `neg` track `acc` in every cycle, including intermediate MAC cycles. `ovf` is visible as soon as it is set.
- No command is accepted while in RUN or DONE. Back-to-back `cmd_valid` waits for IDLE.

## Test plan
- **Reset check:** assert `reset` 2 cycles with `cmd_valid` = 1 → no accept. `acc` = 0x0000, `zero` = 1, `ovf` = 0, `done` = 0. `cmd_ready` is 0 during reset and 1 in the first cycle after release.
- **LOAD then ADD:** LOAD 0x1234, then ADD 0x0001. Expect `acc` 0x1234, then 0x1235. `done` is high exactly 1 cycle, at E1 of each command. `cmd_ready` is low for 2 cycles per command.
- **SUB below zero:** LOAD 0x0005, SUB 0x0007 → `acc` 0xFFFE, `neg` 1, `ovf` 0.
- **Overflow and wrap:**
  - LOAD 0x7FFF, ADD 0x0001 → 0x8000, `ovf` 1, `neg` 1.
  - Then LOAD 0xFFFF, ADD 0x0001 → 0x0000, `zero` 1, `ovf` 0 (cleared on accept; no signed overflow).
  - Then LOAD 0x8000, SUB 0x0001 → 0x7FFF, `ovf` 1.
- **MAC:**
  - LOAD 10, then MAC operand 3 count 4. `acc` steps 13, 16, 19, 22 on E1..E4; `done` is high in the cycle after E4.
  - MAC count 0 → `acc` stays 22, `done` after 1 RUN cycle.
  - MAC 0x4000 count 3 from 0 → 0xC000, `ovf` 1 (sticky).
- **Reset mid-MAC:** start MAC count 15 operand 1 and assert `reset` during the 3rd RUN cycle. Expect `acc` 0x0000, no `done` pulse ever, and `cmd_ready` 1 in the first cycle after release. A new LOAD 0x00AA then completes normally.

Source files
------------

// File: rtl/acc16_seq.sv
// Sequential accumulator controller with LOAD/ADD/SUB/MAC commands over valid/ready.
// Drives one 16-bit ripple add/sub stage (alu4) with the accumulator and the latched operand.

module alu4 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             opcode,
   output logic [WIDTH-1:0] sum
);
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] carry;

   // Subtraction is in1 + ~in2 + 1, so opcode doubles as the carry-in.
   assign b_x      = in2 ^ {WIDTH{opcode}};
   assign carry[0] = opcode;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
         assign sum[gi] = in1[gi] ^ b_x[gi] ^ carry[gi];
         if (gi < WIDTH - 1) begin : g_carry
            assign carry[gi+1] = (in1[gi] & b_x[gi]) | (carry[gi] & (in1[gi] ^ b_x[gi]));
         end
      end
   endgenerate
endmodule

module acc16_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   input  logic [3:0]       cmd_count,
   output logic [WIDTH-1:0] acc,
   output logic             done,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MAC  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             skip_q, skip_d;
   logic             ovf_q, ovf_d;

   logic             is_sub;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] b_x;
   logic             ovf_hit;
   logic             accept;

   assign is_sub = (op_q == OP_SUB);

   alu4 #(.WIDTH(WIDTH)) u_alu (
      .in1    (acc_q),
      .in2    (operand_q),
      .opcode (is_sub),
      .sum    (alu_res)
   );

   // Signed overflow: both effective addends share a sign the result does not.
   assign b_x     = operand_q ^ {WIDTH{is_sub}};
   assign ovf_hit = (acc_q[WIDTH-1] == b_x[WIDTH-1]) && (alu_res[WIDTH-1] != acc_q[WIDTH-1]);

   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      skip_d    = skip_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d      = cmd_op;
               operand_d = cmd_operand;
               // MAC with count 0 still spends one RUN cycle, but leaves acc alone.
               skip_d    = (cmd_op == OP_MAC) && (cmd_count == 4'd0);
               cnt_d     = ((cmd_op == OP_MAC) && (cmd_count != 4'd0)) ? cmd_count : 4'd1;
               ovf_d     = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - 4'd1;
            if (op_q == OP_LOAD) begin
               acc_d = operand_q;
            end else if (!skip_q) begin
               acc_d = alu_res;
               if (ovf_hit) begin
                  ovf_d = 1'b1;
               end
            end
            if (cnt_q == 4'd1) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         operand_q <= '0;
         op_q      <= 2'b00;
         cnt_q     <= 4'd0;
         skip_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         skip_q    <= skip_d;
         ovf_q     <= ovf_d;
      end
   end

   assign acc  = acc_q;
   assign done = (state_q == S_DONE);
   assign zero = (acc_q == '0);
   assign neg  = acc_q[WIDTH-1];
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_acc16_seq.sv
// Self-checking bench for acc16_seq: directed scenarios plus randomized commands
// compared against a signed-arithmetic reference model.

module tb_acc16_seq;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_operand;
   logic [3:0]  cmd_count;
   logic [15:0] acc;
   logic        done;
   logic        zero;
   logic        neg;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   // Reference model state and expected per-RUN-cycle trace.
   logic [15:0] m_acc;
   logic        m_ovf;
   logic [15:0] exp_acc [1:16];
   logic        exp_ovf [1:16];

   // Observations captured by run_cmd.
   logic [15:0] obs_acc  [1:16];
   logic        obs_ovf  [1:16];
   logic        obs_zero [1:16];
   logic        obs_neg  [1:16];
   logic        obs_done [1:17];
   logic        obs_ready_run;
   logic        obs_ready_after;
   logic        obs_accepted;
   int          obs_k;

   acc16_seq #(.WIDTH(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .cmd_count   (cmd_count),
      .acc         (acc),
      .done        (done),
      .zero        (zero),
      .neg         (neg),
      .ovf         (ovf)
   );

   always #5 clk = ~clk;

   task automatic mdl_cmd(input logic [1:0] op, input logic [15:0] opd, input logic [3:0] cnt);
      int k;
      int s;
      k = (op == 2'd3 && cnt != 4'd0) ? int'(cnt) : 1;
      m_ovf = 1'b0;
      for (int i = 1; i <= k; i++) begin
         if (op == 2'd0) begin
            m_acc = opd;
         end else if (!(op == 2'd3 && cnt == 4'd0)) begin
            if (op == 2'd2) s = int'($signed(m_acc)) - int'($signed(opd));
            else            s = int'($signed(m_acc)) + int'($signed(opd));
            if (s > 32767 || s < -32768) m_ovf = 1'b1;
            m_acc = s[15:0];
         end
         exp_acc[i] = m_acc;
         exp_ovf[i] = m_ovf;
      end
   endtask

   // Issues one command, samples 1 time unit after each edge, scrambles cmd_* after accept.
   task automatic run_cmd(input logic [1:0] op, input logic [15:0] opd, input logic [3:0] cnt);
      int n;
      obs_k        = (op == 2'd3 && cnt != 4'd0) ? int'(cnt) : 1;
      obs_accepted = 1'b1;
      cmd_valid    = 1'b1;
      cmd_op       = op;
      cmd_operand  = opd;
      cmd_count    = cnt;
      n = 0;
      while (cmd_ready !== 1'b1) begin
         @(posedge clk); #1;
         n++;
         if (n > 50) begin
            obs_accepted = 1'b0;
            cmd_valid    = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      obs_ready_run = cmd_ready;
      cmd_valid   = 1'($urandom_range(0, 1));
      cmd_op      = 2'($urandom_range(0, 3));
      cmd_operand = 16'($urandom);
      cmd_count   = 4'($urandom_range(0, 15));
      for (int i = 1; i <= obs_k; i++) begin
         @(posedge clk); #1;
         obs_acc[i]  = acc;
         obs_ovf[i]  = ovf;
         obs_zero[i] = zero;
         obs_neg[i]  = neg;
         obs_done[i] = done;
         obs_ready_run = obs_ready_run | cmd_ready;
      end
      @(posedge clk); #1;
      obs_done[obs_k+1] = done;
      obs_ready_after   = cmd_ready;
      cmd_valid = 1'b0;
      $display("txn op=%0d operand=%h count=%0d k=%0d acc=%h ovf=%b", op, opd, cnt, obs_k, acc, obs_ovf[obs_k]);
   endtask

   task automatic test_reset;
      reset       = 1'b1;
      cmd_valid   = 1'b1;
      cmd_op      = 2'd0;
      cmd_operand = 16'h5555;
      cmd_count   = 4'd0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs ready=%b done=%b required ready=0 done=0", cmd_ready, done);
         end
      end
      checks++;
      if ({acc, zero, neg, ovf} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state acc=%h zero=%b neg=%b ovf=%b required 0000 1 0 0", acc, zero, neg, ovf);
      end
      reset     = 1'b0;
      cmd_valid = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release ready=%b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (acc !== 16'h0000 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept acc=%h done=%b required 0000 0", acc, done);
      end
      m_acc = 16'h0000;
      m_ovf = 1'b0;
   endtask

   task automatic test_load_add;
      logic [1:0]  ops [2]  = '{2'd0, 2'd1};
      logic [15:0] opds [2] = '{16'h1234, 16'h0001};
      logic [15:0] fin [2]  = '{16'h1234, 16'h1235};
      for (int j = 0; j < 2; j++) begin
         run_cmd(ops[j], opds[j], 4'd0);
         mdl_cmd(ops[j], opds[j], 4'd0);
         checks++;
         if (!obs_accepted || obs_ready_run !== 1'b0 || obs_done[2] !== 1'b0 || obs_ready_after !== 1'b1) begin
            errors++;
            $display("FAIL load_add_hs cmd=%0d acc_ok=%b ready_run=%b done_after=%b ready_after=%b required 1 0 0 1",
                     j, obs_accepted, obs_ready_run, obs_done[2], obs_ready_after);
         end
         checks++;
         if ({obs_acc[1], obs_done[1], obs_ovf[1]} !== {fin[j], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL load_add cmd=%0d acc=%h done=%b ovf=%b required %h 1 0", j, obs_acc[1], obs_done[1], obs_ovf[1], fin[j]);
         end
      end
   endtask

   task automatic test_sub_ovf_wrap;
      logic [1:0]  ops [8]  = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};
      logic [15:0] opds [8] = '{16'h0005, 16'h0007, 16'h7FFF, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000, 16'h0001};
      logic [15:0] fin [8]  = '{16'h0005, 16'hFFFE, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
      logic        fovf [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int j = 0; j < 8; j++) begin
         run_cmd(ops[j], opds[j], 4'd0);
         mdl_cmd(ops[j], opds[j], 4'd0);
         checks++;
         if ({obs_acc[1], obs_ovf[1], obs_zero[1], obs_neg[1], obs_done[1]} !==
             {fin[j], fovf[j], fin[j] == 16'h0000, fin[j][15], 1'b1} || !obs_accepted) begin
            errors++;
            $display("FAIL sub_ovf cmd=%0d acc=%h ovf=%b zero=%b neg=%b done=%b required %h %b %b %b 1",
                     j, obs_acc[1], obs_ovf[1], obs_zero[1], obs_neg[1], obs_done[1],
                     fin[j], fovf[j], fin[j] == 16'h0000, fin[j][15]);
         end
      end
   endtask

   task automatic test_mac;
      logic [1:0]  ops [5]  = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd3};
      logic [15:0] opds [5] = '{16'd10, 16'd3, 16'h1111, 16'h0000, 16'h4000};
      logic [3:0]  cnts [5] = '{4'd0, 4'd4, 4'd0, 4'd0, 4'd3};
      logic [15:0] fin [5]  = '{16'd10, 16'd22, 16'd22, 16'h0000, 16'hC000};
      logic        fovf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] steps [4] = '{16'd13, 16'd16, 16'd19, 16'd22};
      for (int j = 0; j < 5; j++) begin
         run_cmd(ops[j], opds[j], cnts[j]);
         mdl_cmd(ops[j], opds[j], cnts[j]);
         for (int i = 1; i <= obs_k; i++) begin
            checks++;
            if ({obs_acc[i], obs_ovf[i], obs_done[i]} !== {exp_acc[i], exp_ovf[i], i == obs_k}) begin
               errors++;
               $display("FAIL mac_trace cmd=%0d cyc=%0d acc=%h ovf=%b done=%b required %h %b %b",
                        j, i, obs_acc[i], obs_ovf[i], obs_done[i], exp_acc[i], exp_ovf[i], i == obs_k);
            end
         end
         if (j == 1) begin
            for (int i = 1; i <= 4; i++) begin
               checks++;
               if (obs_acc[i] !== steps[i-1]) begin
                  errors++;
                  $display("FAIL mac_steps cyc=%0d acc=%h required %h", i, obs_acc[i], steps[i-1]);
               end
            end
         end
         checks++;
         if ({obs_acc[obs_k], obs_ovf[obs_k], obs_done[obs_k+1], obs_ready_after} !== {fin[j], fovf[j], 1'b0, 1'b1} || !obs_accepted) begin
            errors++;
            $display("FAIL mac_final cmd=%0d acc=%h ovf=%b done_after=%b ready_after=%b required %h %b 0 1",
                     j, obs_acc[obs_k], obs_ovf[obs_k], obs_done[obs_k+1], obs_ready_after, fin[j], fovf[j]);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic        done_seen;
      logic [15:0] start;
      int          n;
      start       = m_acc;
      done_seen   = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = 2'd3;
      cmd_operand = 16'h0001;
      cmd_count   = 4'd15;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         done_seen = done_seen | done;
      end
      checks++;
      if (acc !== 16'(start + 16'd2)) begin
         errors++;
         $display("FAIL reset_mid_progress acc=%h required %h", acc, 16'(start + 16'd2));
      end
      reset = 1'b1;
      @(posedge clk); #1;
      done_seen = done_seen | done;
      checks++;
      if ({acc, zero, ovf, cmd_ready} !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_state acc=%h zero=%b ovf=%b ready=%b required 0000 1 0 0", acc, zero, ovf, cmd_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_release ready=%b required 1", cmd_ready);
      end
      repeat (20) begin
         @(posedge clk); #1;
         done_seen = done_seen | done;
      end
      checks++;
      if (done_seen !== 1'b0 || acc !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid_nodone done_seen=%b acc=%h required 0 0000", done_seen, acc);
      end
      m_acc = 16'h0000;
      m_ovf = 1'b0;
      run_cmd(2'd0, 16'h00AA, 4'd0);
      mdl_cmd(2'd0, 16'h00AA, 4'd0);
      checks++;
      if ({obs_acc[1], obs_done[1], obs_ready_after} !== {16'h00AA, 1'b1, 1'b1} || !obs_accepted) begin
         errors++;
         $display("FAIL reset_mid_reload acc=%h done=%b ready_after=%b required 00aa 1 1", obs_acc[1], obs_done[1], obs_ready_after);
      end
   endtask

   // Random commands with 0..2 idle cycles between them; gap 0 exercises back-to-back issue.
   task automatic test_random;
      logic [1:0]  op;
      logic [15:0] opd;
      logic [3:0]  cnt;
      logic [19:0] got_v;
      logic [19:0] exp_v;
      for (int j = 0; j < 40; j++) begin
         op  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       opd = 16'h7FFF;
            1:       opd = 16'h8000;
            default: opd = 16'($urandom);
         endcase
         cnt = 4'($urandom_range(0, 15));
         run_cmd(op, opd, cnt);
         mdl_cmd(op, opd, cnt);
         checks++;
         if (!obs_accepted || obs_ready_run !== 1'b0 || obs_done[obs_k+1] !== 1'b0 || obs_ready_after !== 1'b1) begin
            errors++;
            $display("FAIL rand_hs cmd=%0d acc_ok=%b ready_run=%b done_after=%b ready_after=%b required 1 0 0 1",
                     j, obs_accepted, obs_ready_run, obs_done[obs_k+1], obs_ready_after);
         end
         for (int i = 1; i <= obs_k; i++) begin
            exp_v = {exp_acc[i], exp_ovf[i], i == obs_k, exp_acc[i] == 16'h0000, exp_acc[i][15]};
            got_v = {obs_acc[i], obs_ovf[i], obs_done[i], obs_zero[i], obs_neg[i]};
            checks++;
            if (got_v !== exp_v) begin
               errors++;
               $display("FAIL rand_trace cmd=%0d op=%0d cyc=%0d got acc=%h ovf,done,zero,neg=%b required acc=%h flags=%b",
                        j, op, i, got_v[19:4], got_v[3:0], exp_v[19:4], exp_v[3:0]);
            end
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 2'd0;
      cmd_operand = 16'h0000;
      cmd_count   = 4'd0;
      m_acc       = 16'h0000;
      m_ovf       = 1'b0;
      test_reset();
      test_load_add();
      test_sub_ovf_wrap();
      test_mac();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
